// File: rtl/hit_tx_pkg.sv
// hit_tx_pkg: register map, FSM state and reset defaults shared by
// hit_transmit and hit_tx_chan.
package hit_tx_pkg;

    localparam logic [7:0] ADDR_PERIOD    = 8'h00;
    localparam logic [7:0] ADDR_BURST     = 8'h01;
    localparam logic [7:0] ADDR_SWEEP_MAX = 8'h02;
    localparam logic [7:0] ADDR_DELAY     = 8'h10;
    localparam logic [7:0] ADDR_WIDTH     = 8'h20;

    localparam int unsigned MIN_PERIOD = 2;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic int unsigned def_period(input int unsigned clk_freq);
        return clk_freq / 1000000;
    endfunction

    function automatic int unsigned def_width();
        return 4;
    endfunction

endpackage

// File: rtl/hit_tx_chan.sv
// hit_tx_chan: one hit channel -- staging/active DELAY and WIDTH
// registers plus the registered window comparator.
module hit_tx_chan
    import hit_tx_pkg::*;
#(
    parameter int CH         = 0,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_wr,
    input  logic [7:0]            cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  load,
    input  logic                  run,
    input  logic [DATA_WIDTH-1:0] fcnt,
    input  logic [DATA_WIDTH-1:0] offset,
    output logic                  hit
);

    localparam logic [DATA_WIDTH-1:0] WIDTH_RST = DATA_WIDTH'(def_width());
    localparam logic [7:0] A_DLY = ADDR_DELAY + 8'(CH);
    localparam logic [7:0] A_WID = ADDR_WIDTH + 8'(CH);

    logic [DATA_WIDTH-1:0] dly_stg_q, dly_stg_d;
    logic [DATA_WIDTH-1:0] wid_stg_q, wid_stg_d;
    logic [DATA_WIDTH-1:0] dly_q, dly_d;
    logic [DATA_WIDTH-1:0] wid_q, wid_d;
    logic                  hit_q, hit_d;
    logic [DATA_WIDTH:0]   d_eff;
    logic [DATA_WIDTH+1:0] d_end;

    always_comb begin
        dly_stg_d = dly_stg_q;
        wid_stg_d = wid_stg_q;
        if (cfg_wr && cfg_addr == A_DLY) dly_stg_d = cfg_data;
        if (cfg_wr && cfg_addr == A_WID) wid_stg_d = cfg_data;
        dly_d = load ? dly_stg_q : dly_q;
        wid_d = load ? wid_stg_q : wid_q;
        // Extra bits keep D+WIDTH from wrapping; the frame end truncates.
        d_eff = {1'b0, dly_q} + {1'b0, offset};
        d_end = {1'b0, d_eff} + {2'b00, wid_q};
        hit_d = run && (wid_q != '0)
             && ({1'b0, fcnt} >= d_eff)
             && ({2'b00, fcnt} < d_end);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dly_stg_q <= '0;
            wid_stg_q <= WIDTH_RST;
            dly_q     <= '0;
            wid_q     <= WIDTH_RST;
            hit_q     <= 1'b0;
        end else begin
            dly_stg_q <= dly_stg_d;
            wid_stg_q <= wid_stg_d;
            dly_q     <= dly_d;
            wid_q     <= wid_d;
            hit_q     <= hit_d;
        end
    end

    assign hit = hit_q;

endmodule

// File: rtl/hit_transmit.sv
// hit_transmit: programmable start/stop hit-pulse generator for TDC
// loop-back; optional delay sweep compiled in with HIT_TX_SWEEP_EN.
module hit_transmit
    import hit_tx_pkg::*;
#(
    parameter int CHANNEL    = 8,
    parameter int DATA_WIDTH = 32,
    parameter int CLK_FREQ   = 200000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_wr,
    input  logic [7:0]            cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_data,
    input  logic                  start,
    input  logic                  stop,
    output logic                  busy,
    output logic                  frame_strobe,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] frames_sent,
    output logic [CHANNEL-1:0]    hit
);

    localparam logic [DATA_WIDTH-1:0] PERIOD_RST =
        DATA_WIDTH'(def_period(CLK_FREQ));
    localparam logic [DATA_WIDTH-1:0] PMIN = DATA_WIDTH'(MIN_PERIOD);
    localparam logic [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [DATA_WIDTH-1:0] frames_q, frames_d;
    logic                  stop_q, stop_d;
    logic                  done_q, done_d;
    logic                  strobe_q, strobe_d;
    logic [DATA_WIDTH-1:0] period_stg_q, period_stg_d;
    logic [DATA_WIDTH-1:0] period_act_q, period_act_d;
    logic [DATA_WIDTH-1:0] burst_stg_q, burst_stg_d;
    logic [DATA_WIDTH-1:0] burst_act_q, burst_act_d;
    logic [DATA_WIDTH-1:0] offset;
`ifdef HIT_TX_SWEEP_EN
    logic [DATA_WIDTH-1:0] sweep_stg_q, sweep_stg_d;
    logic [DATA_WIDTH-1:0] sweep_act_q, sweep_act_d;
    logic [DATA_WIDTH-1:0] offset_q, offset_d;
`endif

    logic run, go, wrap, last, fin, load;

    always_comb begin
        run  = (state_q == RUN);
        go   = !run && start;
        wrap = run && (fcnt_q == period_act_q - ONE);
        last = ({1'b0, frames_q} + (DATA_WIDTH+1)'(1))
            == {1'b0, burst_act_q};
        fin  = wrap && (stop_q || stop
                        || (burst_act_q != '0 && last));
        load = go || wrap;

        period_stg_d = period_stg_q;
        burst_stg_d  = burst_stg_q;
`ifdef HIT_TX_SWEEP_EN
        sweep_stg_d  = sweep_stg_q;
`endif
        if (cfg_wr) begin
            unique case (cfg_addr)
                ADDR_PERIOD: period_stg_d = cfg_data;
                ADDR_BURST:  burst_stg_d  = cfg_data;
`ifdef HIT_TX_SWEEP_EN
                ADDR_SWEEP_MAX: sweep_stg_d = cfg_data;
`endif
                default: ;
            endcase
        end

        // Active copies change only at a frame edge so no frame mixes settings.
        period_act_d = period_act_q;
        burst_act_d  = burst_act_q;
        if (load) begin
            period_act_d = (period_stg_q < PMIN) ? PMIN : period_stg_q;
            burst_act_d  = burst_stg_q;
        end

        state_d = state_q;
        if (go)       state_d = RUN;
        else if (fin) state_d = IDLE;

        fcnt_d = (run && !wrap) ? fcnt_q + ONE : '0;

        frames_d = frames_q;
        if (go)                        frames_d = '0;
        else if (wrap && frames_q != '1) frames_d = frames_q + ONE;

        stop_d = stop_q;
        if (!run)      stop_d = go && stop;
        else if (fin)  stop_d = 1'b0;
        else if (stop) stop_d = 1'b1;

        done_d   = fin;
        strobe_d = run && (fcnt_q == '0);

`ifdef HIT_TX_SWEEP_EN
        sweep_act_d = load ? sweep_stg_q : sweep_act_q;
        offset_d    = offset_q;
        if (go)
            offset_d = '0;
        else if (wrap)
            offset_d = (offset_q >= sweep_act_q) ? '0 : offset_q + ONE;
`endif
    end

`ifdef HIT_TX_SWEEP_EN
    assign offset = offset_q;
`else
    assign offset = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fcnt_q       <= '0;
            frames_q     <= '0;
            stop_q       <= 1'b0;
            done_q       <= 1'b0;
            strobe_q     <= 1'b0;
            period_stg_q <= PERIOD_RST;
            period_act_q <= PERIOD_RST;
            burst_stg_q  <= '0;
            burst_act_q  <= '0;
`ifdef HIT_TX_SWEEP_EN
            sweep_stg_q  <= '0;
            sweep_act_q  <= '0;
            offset_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            fcnt_q       <= fcnt_d;
            frames_q     <= frames_d;
            stop_q       <= stop_d;
            done_q       <= done_d;
            strobe_q     <= strobe_d;
            period_stg_q <= period_stg_d;
            period_act_q <= period_act_d;
            burst_stg_q  <= burst_stg_d;
            burst_act_q  <= burst_act_d;
`ifdef HIT_TX_SWEEP_EN
            sweep_stg_q  <= sweep_stg_d;
            sweep_act_q  <= sweep_act_d;
            offset_q     <= offset_d;
`endif
        end
    end

    // Channel 0 is the start reference and is never swept.
    for (genvar ch = 0; ch < CHANNEL; ch++) begin : g_chan
        hit_tx_chan #(
            .CH         (ch),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .cfg_wr   (cfg_wr),
            .cfg_addr (cfg_addr),
            .cfg_data (cfg_data),
            .load     (load),
            .run      (run),
            .fcnt     (fcnt_q),
            .offset   ((ch == 0) ? '0 : offset),
            .hit      (hit[ch])
        );
    end

    assign busy         = (state_q == RUN);
    assign frame_strobe = strobe_q;
    assign done         = done_q;
    assign frames_sent  = frames_q;

endmodule

// File: tb/tb_hit_transmit.sv
// tb_hit_transmit: table-driven bursts with a rise-time scoreboard
// on hit[1], plus hand-written corner-case sequences.
module tb_hit_transmit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [7:0]  cfg_addr = 8'h00;
    logic [31:0] cfg_data = 32'h0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy, frame_strobe, done;
    logic [31:0] frames_sent;
    logic [7:0]  hit;

    int cyc = 0;
    int npass = 0;
    int ntot = 0;
    int sbq[$];

    typedef struct {
        logic [31:0] p, b, d1, w1, d2, w2;
        int peff, nb, nh1, nh2, nh3;
    } vec_t;

    typedef struct {
        int nb, nh1, nh2, nh3, ns, nsa, nd, dcyc;
    } mon_t;

    vec_t vecs[4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hit_transmit #(
        .CHANNEL    (8),
        .DATA_WIDTH (32),
        .CLK_FREQ   (200000000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .start        (start),
        .stop         (stop),
        .busy         (busy),
        .frame_strobe (frame_strobe),
        .done         (done),
        .frames_sent  (frames_sent),
        .hit          (hit)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic at_cycle(input int x);
        while (cyc < x) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input logic [7:0] a, input logic [31:0] d);
        cfg_wr = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
    endtask

    task automatic pulse_start(input logic with_stop, output int ts);
        start = 1'b1;
        stop = with_stop;
        ts = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        stop = 1'b0;
    endtask

    task automatic run_mon(input int budget, output mon_t m);
        int tail;
        int e;
        logic ph1;
        tail = 0;
        ph1 = 1'b0;
        m = '{0, 0, 0, 0, 0, 0, 0, -1};
        for (int n = 0; n < budget && tail < 4; n++) begin
            @(negedge clk);
            if (busy) m.nb++;
            if (hit[1]) m.nh1++;
            if (hit[2]) m.nh2++;
            if (hit[3]) m.nh3++;
            if (frame_strobe) m.ns++;
            if (frame_strobe && hit[0]) m.nsa++;
            if (done) begin
                m.nd++;
                if (m.dcyc < 0) m.dcyc = cyc;
            end
            if (hit[1] && !ph1) begin
                if (sbq.size() == 0) begin
                    chk("sb_extra_rise", cyc, -1);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_rise_cycle", cyc, e);
                end
            end
            ph1 = hit[1];
            if (m.nd > 0) tail++;
        end
        chk("mon_done_seen", (m.dcyc >= 0) ? 1 : 0, 1);
        chk("sb_empty", sbq.size(), 0);
        sbq.delete();
    endtask

    initial begin
        int ts;
        int first_s, n_ff, n_any, n_al, n_bz, n_s, dc;
        mon_t m;

        vecs[0] = '{32'd10, 32'd3, 32'd3, 32'd2, 32'd8, 32'd5, 10, 30, 6, 6, 0};
        vecs[1] = '{32'd10, 32'd2, 32'd12, 32'd2, 32'd0, 32'd0, 10, 20, 0, 0, 0};
        vecs[2] = '{32'd1, 32'd4, 32'd1, 32'd3, 32'd0, 32'd1, 2, 8, 4, 4, 0};
        vecs[3] = '{32'd16, 32'd1, 32'd15, 32'd1, 32'd4, 32'hFFFF_FFFF,
                    16, 16, 1, 12, 4};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hit", hit, 0);
        chk("rst_strobe", frame_strobe, 0);
        chk("rst_done", done, 0);
        chk("rst_frames", frames_sent, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Defaults: 200-cycle frames, every channel 4 cycles at offset 0.
        pulse_start(1'b0, ts);
        first_s = -1;
        n_ff = 0; n_any = 0; n_al = 0; n_bz = 0; n_s = 0;
        for (int n = 0; n < 450; n++) begin
            @(negedge clk);
            if (busy) n_bz++;
            if (hit == 8'hFF) n_ff++;
            if (hit != 8'h00) n_any++;
            if (frame_strobe) begin
                n_s++;
                if (first_s < 0) first_s = cyc;
                if (hit == 8'hFF) n_al++;
            end
        end
        chk("def_first_strobe", first_s, ts + 2);
        chk("def_strobes", n_s, 3);
        chk("def_hit_all", n_ff, 12);
        chk("def_hit_any", n_any, 12);
        chk("def_aligned", n_al, 3);
        chk("def_busy", n_bz, 450);
        chk("def_frames_mid", frames_sent, 2);
        @(posedge clk);
        #1;
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        dc = -1;
        for (int n = 0; n < 400 && dc < 0; n++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                chk("stop_busy_low", busy, 0);
                chk("stop_frames", frames_sent, 3);
            end
        end
        chk("stop_done_cycle", dc, ts + 601);
        @(posedge clk);
        #1;

        cfg(8'h13, 32'd12);
        foreach (vecs[i]) begin
            cfg(8'h00, vecs[i].p);
            cfg(8'h01, vecs[i].b);
            cfg(8'h11, vecs[i].d1);
            cfg(8'h21, vecs[i].w1);
            cfg(8'h12, vecs[i].d2);
            cfg(8'h22, vecs[i].w2);
            pulse_start(1'b0, ts);
            for (int f = 0; f < int'(vecs[i].b); f++)
                if (vecs[i].w1 != 0 && int'(vecs[i].d1) < vecs[i].peff)
                    sbq.push_back(ts + 2 + f * vecs[i].peff + int'(vecs[i].d1));
            run_mon(400, m);
            chk($sformatf("v%0d_busy", i), m.nb, vecs[i].nb);
            chk($sformatf("v%0d_h1", i), m.nh1, vecs[i].nh1);
            chk($sformatf("v%0d_h2", i), m.nh2, vecs[i].nh2);
            chk($sformatf("v%0d_h3", i), m.nh3, vecs[i].nh3);
            chk($sformatf("v%0d_strobes", i), m.ns, int'(vecs[i].b));
            chk($sformatf("v%0d_h0_align", i), m.nsa, int'(vecs[i].b));
            chk($sformatf("v%0d_done", i), m.nd, 1);
            chk($sformatf("v%0d_done_cyc", i), m.dcyc, ts + 1 + vecs[i].nb);
            chk($sformatf("v%0d_frames", i), frames_sent, int'(vecs[i].b));
        end

        // Mid-frame DELAY write, start ignored in RUN, stop mid-frame.
        cfg(8'h00, 32'd10);
        cfg(8'h01, 32'd0);
        cfg(8'h11, 32'd3);
        cfg(8'h21, 32'd2);
        pulse_start(1'b0, ts);
        sbq.push_back(ts + 5);
        sbq.push_back(ts + 18);
        sbq.push_back(ts + 28);
        fork
            run_mon(200, m);
            begin
                at_cycle(ts + 3);
                cfg(8'h11, 32'd6);
                at_cycle(ts + 15);
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                at_cycle(ts + 25);
                stop = 1'b1;
                @(posedge clk);
                #1;
                stop = 1'b0;
            end
        join
        chk("mid_busy", m.nb, 30);
        chk("mid_h1", m.nh1, 6);
        chk("mid_done_cyc", m.dcyc, ts + 31);
        chk("mid_frames", frames_sent, 3);

        pulse_start(1'b1, ts);
        sbq.push_back(ts + 8);
        run_mon(100, m);
        chk("ss_busy", m.nb, 10);
        chk("ss_done", m.nd, 1);
        chk("ss_done_cyc", m.dcyc, ts + 11);
        chk("ss_frames", frames_sent, 1);

`ifdef HIT_TX_SWEEP_EN
        cfg(8'h00, 32'd20);
        cfg(8'h01, 32'd5);
        cfg(8'h02, 32'd3);
        cfg(8'h11, 32'd5);
        cfg(8'h21, 32'd1);
        pulse_start(1'b0, ts);
        sbq.push_back(ts + 2 + 5);
        sbq.push_back(ts + 22 + 6);
        sbq.push_back(ts + 42 + 7);
        sbq.push_back(ts + 62 + 8);
        sbq.push_back(ts + 82 + 5);
        run_mon(300, m);
        chk("sw_h1", m.nh1, 5);
        chk("sw_h0_align", m.nsa, 5);
        chk("sw_frames", frames_sent, 5);
`endif

        // Reset in the middle of a pulse.
        cfg(8'h00, 32'd10);
        cfg(8'h01, 32'd0);
        pulse_start(1'b0, ts);
        at_cycle(ts + 3);
        @(negedge clk);
        chk("rb_pre_busy", busy, 1);
        chk("rb_pre_hit0", hit[0], 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rb_busy", busy, 0);
        chk("rb_hit", hit, 0);
        chk("rb_strobe", frame_strobe, 0);
        chk("rb_done", done, 0);
        chk("rb_frames", frames_sent, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
